// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, 1 or 2 stop bits.
// A byte is taken through a valid/ready handshake and serialised on txd,
// which idles high. Bit timing is derived from clk via a baud counter.
// All outputs are registered so txd is glitch-free.

module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  // Baud counter is just wide enough to hold CLKS_PER_BIT-1, never narrower than 1 bit.
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  // Index of the last stop period as seen by the bit counter.
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [BW-1:0]   baud_cnt;
  logic [BW-1:0]   baud_next;
  logic [3:0]      bit_cnt;
  logic [3:0]      bit_next;
  logic [7:0]      shift_reg;
  logic [7:0]      shift_next;
  logic            accept;
  logic            bit_end;
  logic            data_last;
  logic            stop_last;
  logic            txd_next;
  logic            ready_next;
  logic            busy_next;
  logic            done_next;

  assign accept    = tx_valid & tx_ready;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign data_last = (bit_cnt == 4'd7);
  assign stop_last = (bit_cnt == STOP_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each state advances only at the end of its bit period.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (bit_end && data_last) begin
          state_next = STOP;
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (bit_end && stop_last) begin
          state_next = IDLE;
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath next values: baud phase, bit index and the shifting data copy.
  always_comb begin
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    case (state)
      IDLE: begin
        // Phase restarts at zero so each frame is aligned to its accept edge.
        baud_next = BAUD_ZERO;
        bit_next  = 4'd0;
        if (accept) begin
          shift_next = tx_data;
        end else begin
          shift_next = shift_reg;
        end
      end
      START: begin
        baud_next = bit_end ? BAUD_ZERO : (baud_cnt + BAUD_ONE);
        bit_next  = 4'd0;
      end
      DATA: begin
        baud_next = bit_end ? BAUD_ZERO : (baud_cnt + BAUD_ONE);
        if (bit_end) begin
          bit_next   = data_last ? 4'd0 : (bit_cnt + 4'd1);
          shift_next = {1'b0, shift_reg[7:1]};
        end else begin
          bit_next   = bit_cnt;
          shift_next = shift_reg;
        end
      end
      STOP: begin
        baud_next = bit_end ? BAUD_ZERO : (baud_cnt + BAUD_ONE);
        if (bit_end) begin
          bit_next = stop_last ? 4'd0 : (bit_cnt + 4'd1);
        end else begin
          bit_next = bit_cnt;
        end
      end
      default: begin
        baud_next = BAUD_ZERO;
        bit_next  = 4'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= BAUD_ZERO;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'd0;
    end else begin
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    txd_next   = 1'b1;
    ready_next = 1'b1;
    busy_next  = 1'b0;
    case (state_next)
      IDLE: begin
        txd_next   = 1'b1;
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
      START: begin
        txd_next   = 1'b0;
        ready_next = 1'b0;
        busy_next  = 1'b1;
      end
      DATA: begin
        txd_next   = shift_next[0];
        ready_next = 1'b0;
        busy_next  = 1'b1;
      end
      STOP: begin
        txd_next   = 1'b1;
        ready_next = 1'b0;
        busy_next  = 1'b1;
      end
      default: begin
        txd_next   = 1'b1;
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
    done_next = (state == STOP) && (state_next == IDLE);
  end

  // Output registers; reset forces the line back to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      txd      <= txd_next;
      tx_ready <= ready_next;
      tx_busy  <= busy_next;
      tx_done  <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Stimulus pushes the expected
// frame into a queue; a line monitor decodes txd and checks each frame.

module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  int         sel;
  int         cyc = 0;
  int         last_acc = -1;
  int         n_vec = 0;
  int         n_bad = 0;

  logic ready_a, txd_a, busy_a, done_a;
  logic ready_b, txd_b, busy_b, done_b;
  logic ready_c, txd_c, busy_c, done_c;
  logic m_ready, m_txd, m_busy, m_done;
  int   m_cpb, m_stop;

  typedef struct {
    logic [7:0] data;
    int         gap;
    bit         abort;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid && (sel == 0)),
    .tx_ready(ready_a), .txd(txd_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid && (sel == 1)),
    .tx_ready(ready_b), .txd(txd_b), .tx_busy(busy_b), .tx_done(done_b));

  uart_tx dut_c (
    .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid && (sel == 2)),
    .tx_ready(ready_c), .txd(txd_c), .tx_busy(busy_c), .tx_done(done_c));

  assign m_ready = (sel == 0) ? ready_a : ((sel == 1) ? ready_b : ready_c);
  assign m_txd   = (sel == 0) ? txd_a   : ((sel == 1) ? txd_b   : txd_c);
  assign m_busy  = (sel == 0) ? busy_a  : ((sel == 1) ? busy_b  : busy_c);
  assign m_done  = (sel == 0) ? done_a  : ((sel == 1) ? done_b  : done_c);
  assign m_cpb   = (sel == 2) ? 434 : 4;
  assign m_stop  = (sel == 1) ? 2 : 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- line monitor / scoreboard ----------------
  int         mst = 0;
  int         k;
  int         busy_cnt;
  int         idle_run = 0;
  logic [7:0] bits;
  bit         lvl_bad;
  bit         early;
  bit         have_exp;
  exp_t       cur;

  always @(negedge clk) begin
    int flen;
    int b;
    flen = m_cpb * (9 + m_stop);
    if (rst) begin
      if (mst == 1 && !(have_exp && cur.abort)) begin
        check("unexpected_abort", 1, 0);
      end
      mst      = 0;
      idle_run = 0;
    end else begin
      if (mst == 0) begin
        if (m_done) check("spurious_done", int'(m_done), 0);
        if (m_txd == 1'b0) begin
          if (q.size() == 0) begin
            have_exp = 1'b0;
            check("unexpected_frame", 1, 0);
          end else begin
            have_exp = 1'b1;
            cur = q.pop_front();
            if (cur.gap >= 0) check("idle_gap", idle_run, cur.gap);
          end
          check("fall_latency", cyc, last_acc);
          mst      = 1;
          k        = 0;
          busy_cnt = 0;
          bits     = 8'd0;
          lvl_bad  = 1'b0;
          early    = 1'b0;
        end else begin
          idle_run++;
        end
      end
      if (mst == 1) begin
        if (k < flen) begin
          if (m_busy) busy_cnt++;
          if (m_done) early = 1'b1;
          if ((k % m_cpb) == (m_cpb / 2)) begin
            b = k / m_cpb;
            if (b == 0) begin
              if (m_txd !== 1'b0) lvl_bad = 1'b1;
            end else if (b <= 8) begin
              bits[b-1] = m_txd;
            end else begin
              if (m_txd !== 1'b1) lvl_bad = 1'b1;
            end
          end
          k++;
        end else begin
          if (have_exp) begin
            check("abort_missed", int'(cur.abort), 0);
            check("frame_data", int'(bits), int'(cur.data));
          end
          check("done_at_end", int'(m_done), 1);
          check("ready_at_end", int'(m_ready), 1);
          check("busy_at_end", int'(m_busy), 0);
          check("busy_cycles", busy_cnt, flen);
          check("start_stop_levels", int'(lvl_bad), 0);
          check("early_done", int'(early), 0);
          mst      = 0;
          idle_run = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, output int acc);
    int n;
    n     = 0;
    acc   = -1;
    data  = d;
    valid = 1'b1;
    while (m_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (m_ready === 1'b1) begin
      @(posedge clk);
      #1;
      acc      = cyc;
      last_acc = cyc;
    end else begin
      check("accept_timeout", n, 0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || mst != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || mst != 0) check("drain_timeout", n, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int acc1;
    int acc2;
    int viol;
    rst   = 1'b1;
    data  = 8'h00;
    valid = 1'b0;
    sel   = 0;
    repeat (3) @(negedge clk);
    check("reset_txd", int'(txd_a), 1);
    check("reset_ready", int'(ready_a), 1);
    check("reset_busy", int'(busy_a), 0);
    check("reset_done", int'(done_a), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single 0xA5 frame, 4 clocks per bit
    q.push_back('{data: 8'hA5, gap: -1, abort: 1'b0});
    send(8'hA5, acc1);
    valid = 1'b0;
    wait_drain();

    // 2: back-to-back 0x00 then 0xFF with valid held
    q.push_back('{data: 8'h00, gap: -1, abort: 1'b0});
    q.push_back('{data: 8'hFF, gap: 1, abort: 1'b0});
    send(8'h00, acc1);
    send(8'hFF, acc2);
    valid = 1'b0;
    check("accept_spacing", acc2 - acc1, 41);
    wait_drain();

    // 3: two stop bits, 0x3C
    sel = 1;
    q.push_back('{data: 8'h3C, gap: -1, abort: 1'b0});
    send(8'h3C, acc1);
    valid = 1'b0;
    wait_drain();

    // 4: tx_data scrambled while busy during 0x5A
    sel  = 0;
    viol = 0;
    q.push_back('{data: 8'h5A, gap: -1, abort: 1'b0});
    send(8'h5A, acc1);
    valid = 1'b0;
    repeat (42) begin
      @(negedge clk);
      data = 8'($urandom);
      if (m_busy && m_ready) viol++;
    end
    check("ready_while_busy", viol, 0);
    wait_drain();

    // 5: reset in the middle of data bit 3 of 0xC3, then send 0x81
    q.push_back('{data: 8'hC3, gap: -1, abort: 1'b1});
    send(8'hC3, acc1);
    valid = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    check("pre_reset_txd_bit3", int'(txd_a), 0);
    check("pre_reset_busy", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    check("abort_txd", int'(txd_a), 1);
    check("abort_ready", int'(ready_a), 1);
    check("abort_busy", int'(busy_a), 0);
    check("abort_done", int'(done_a), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    q.push_back('{data: 8'h81, gap: -1, abort: 1'b0});
    send(8'h81, acc1);
    valid = 1'b0;
    wait_drain();

    // 6: default 434 clocks per bit, 0x55
    sel = 2;
    q.push_back('{data: 8'h55, gap: -1, abort: 1'b0});
    send(8'h55, acc1);
    valid = 1'b0;
    wait_drain();

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
